// File: rtl/lcd_reg_spi_pkg.sv
// -----------------------------------------------------------------------------
// lcd_reg_spi_pkg
// Shared definitions for the LCD register-access serial master.
//   lcdSpiState_t : frame sequencer states, IDLE -> SETUP -> SHIFT -> HOLD -> GAP
//   FRAME_BITS    : bits per frame, {RW, addr[6:0], data[7:0]}
//   RW_READ/WRITE : value of the leading RW bit
//   buildFrame()  : assembles the outgoing frame; data bits are zero on reads
// -----------------------------------------------------------------------------
package lcd_reg_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } lcdSpiState_t;

    localparam int   FRAME_BITS = 16;
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    function automatic logic [FRAME_BITS-1:0] buildFrame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {rw, addr, (rw == RW_READ) ? 8'h00 : data};
    endfunction

endpackage

// File: rtl/lcd_reg_spi_clkgen.sv
// -----------------------------------------------------------------------------
// lcd_reg_spi_clkgen
// SCLK divider. While enabled, produces one SCLK period every 2*CLK_DIV system
// clocks: low for the first CLK_DIV cycles, high for the next CLK_DIV.
// Ports:
//   clk      in  system clock
//   srst     in  synchronous active-high reset
//   enable   in  run the divider; when low the counter and SCLK are held at 0
//   sclk     out registered SCLK level, idles low
//   sclkRise out high in the cycle whose closing edge raises SCLK
//   sclkFall out high in the cycle whose closing edge lowers SCLK (end of bit)
// -----------------------------------------------------------------------------
module lcd_reg_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    output logic sclk,
    output logic sclkRise,
    output logic sclkFall
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] divCntReg;
    logic          sclkReg;

    assign sclkRise = enable && (divCntReg == RISE_AT);
    assign sclkFall = enable && (divCntReg == FALL_AT);
    assign sclk     = sclkReg;

    always_ff @(posedge clk) begin
        if (srst || !enable) begin
            // Holding the counter at zero while disabled makes every SHIFT
            // phase start with a full low half-period.
            divCntReg <= '0;
            sclkReg   <= 1'b0;
        end else begin
            divCntReg <= sclkFall ? '0 : divCntReg + CW'(1);
            if (sclkRise) begin
                sclkReg <= 1'b1;
            end else if (sclkFall) begin
                sclkReg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lcd_reg_spi.sv
// -----------------------------------------------------------------------------
// lcd_reg_spi
// Serial register-access master for the LCD panel's 3-wire config port.
// A write or read strobe for one 7-bit address is serialised as a 16-bit frame
// {RW, addr, data} MSB first; read data is sampled on the last 8 SCLK rises.
// Ports:
//   i_clock, i_reset          system clock, synchronous active-high reset
//   i_txBegin / i_rxBegin     one-cycle write / read strobes (write wins on tie)
//   i_address, i_txData       captured on an accepted strobe
//   i_rxSerial                panel MISO
//   o_clock, o_txSerial       SCLK (idles low), MOSI
//   o_serialEnable            active-high frame enable
//   o_busy                    accepted strobe until back in IDLE
//   o_txDone / o_rxDone       one-cycle completion pulses
//   o_rxData                  last read byte, held until the next read completes
//   o_verifyErr               (LCD_REG_SPI_VERIFY_EN only) readback mismatch, sticky
// Build option LCD_REG_SPI_VERIFY_EN: every write is followed by an automatic
// readback of the same address; o_txDone fires after the readback.
// -----------------------------------------------------------------------------
module lcd_reg_spi #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_txBegin,
    input  logic       i_rxBegin,
    input  logic [6:0] i_address,
    input  logic [7:0] i_txData,
    input  logic       i_rxSerial,
    output logic       o_clock,
    output logic       o_txSerial,
    output logic       o_serialEnable,
    output logic       o_busy,
    output logic       o_txDone,
    output logic       o_rxDone,
`ifdef LCD_REG_SPI_VERIFY_EN
    output logic       o_verifyErr,
`endif
    output logic [7:0] o_rxData
);

    import lcd_reg_spi_pkg::*;

    localparam int PHASE_MAX = (CS_SETUP > CS_HOLD)
                             ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                             : ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
    localparam int CNT_W = $clog2(PHASE_MAX + 1);

    lcdSpiState_t          stateReg, stateNext;
    logic [CNT_W-1:0]      cntReg, cntNext;
    logic [3:0]            bitCntReg, bitCntNext;
    logic [FRAME_BITS-1:0] shiftReg, shiftNext;
    logic [7:0]            rxShiftReg, rxShiftNext;
    logic [7:0]            rxDataReg, rxDataNext;
    logic                  isReadReg, isReadNext;
    logic                  enableReg, enableNext;
    logic                  busyReg, busyNext;
    logic                  txDoneReg, txDoneNext;
    logic                  rxDoneReg, rxDoneNext;
`ifdef LCD_REG_SPI_VERIFY_EN
    logic [6:0]            addrReg, addrNext;
    logic [7:0]            dataReg, dataNext;
    logic                  autoReadReg, autoReadNext;
    logic                  verifyErrReg, verifyErrNext;
`endif

    logic sclk, sclkRise, sclkFall;

    lcd_reg_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (i_clock),
        .srst     (i_reset),
        .enable   (stateReg == SHIFT),
        .sclk     (sclk),
        .sclkRise (sclkRise),
        .sclkFall (sclkFall)
    );

    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        bitCntNext  = bitCntReg;
        shiftNext   = shiftReg;
        rxShiftNext = rxShiftReg;
        rxDataNext  = rxDataReg;
        isReadNext  = isReadReg;
        txDoneNext  = 1'b0;
        rxDoneNext  = 1'b0;
`ifdef LCD_REG_SPI_VERIFY_EN
        addrNext      = addrReg;
        dataNext      = dataReg;
        autoReadNext  = autoReadReg;
        verifyErrNext = verifyErrReg;
`endif
        case (stateReg)
            IDLE: begin
                if (i_txBegin || i_rxBegin) begin
                    isReadNext = !i_txBegin;
                    shiftNext  = buildFrame(i_txBegin ? RW_WRITE : RW_READ, i_address, i_txData);
                    bitCntNext = 4'd15;
                    cntNext    = '0;
                    stateNext  = SETUP;
`ifdef LCD_REG_SPI_VERIFY_EN
                    addrNext      = i_address;
                    dataNext      = i_txData;
                    autoReadNext  = 1'b0;
                    verifyErrNext = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cntReg == CNT_W'(CS_SETUP - 1)) begin
                    cntNext   = '0;
                    stateNext = SHIFT;
                end else begin
                    cntNext = cntReg + CNT_W'(1);
                end
            end
            SHIFT: begin
                // bitCnt 7..0 are the data bits of the frame.
                if (sclkRise && !bitCntReg[3]) begin
                    rxShiftNext = {rxShiftReg[6:0], i_rxSerial};
                end
                // MOSI advances on the falling edge, a half-period ahead of the
                // panel's sampling rise.
                if (sclkFall) begin
                    shiftNext = {shiftReg[FRAME_BITS-2:0], 1'b0};
                    if (bitCntReg == 4'd0) begin
                        cntNext   = '0;
                        stateNext = HOLD;
                    end else begin
                        bitCntNext = bitCntReg - 4'd1;
                    end
                end
            end
            HOLD: begin
                if (cntReg == CNT_W'(CS_HOLD - 1)) begin
                    cntNext   = '0;
                    stateNext = (IDLE_GAP > 1) ? GAP : IDLE;
`ifdef LCD_REG_SPI_VERIFY_EN
                    if (autoReadReg) begin
                        txDoneNext    = 1'b1;
                        verifyErrNext = (rxShiftReg != dataReg);
                        autoReadNext  = 1'b0;
                    end else if (isReadReg) begin
                        rxDoneNext = 1'b1;
                        rxDataNext = rxShiftReg;
                    end else begin
                        // Write frame done; the readback is launched from GAP.
                        stateNext = GAP;
                    end
`else
                    if (isReadReg) begin
                        rxDoneNext = 1'b1;
                        rxDataNext = rxShiftReg;
                    end else begin
                        txDoneNext = 1'b1;
                    end
`endif
                end else begin
                    cntNext = cntReg + CNT_W'(1);
                end
            end
            GAP: begin
                // Enable stays low for IDLE_GAP cycles in total: IDLE_GAP-1 here
                // plus the IDLE cycle in which the next strobe is taken.
`ifdef LCD_REG_SPI_VERIFY_EN
                if (!isReadReg) begin
                    // The readback starts where an external strobe taken on
                    // the first IDLE cycle would, so it sees the same gap.
                    if (cntReg == CNT_W'(IDLE_GAP - 1)) begin
                        isReadNext   = 1'b1;
                        autoReadNext = 1'b1;
                        shiftNext    = buildFrame(RW_READ, addrReg, 8'h00);
                        bitCntNext   = 4'd15;
                        cntNext      = '0;
                        stateNext    = SETUP;
                    end else begin
                        cntNext = cntReg + CNT_W'(1);
                    end
                end else
`endif
                if (cntReg == CNT_W'(IDLE_GAP - 2)) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    cntNext = cntReg + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        enableNext = (stateNext == SETUP) || (stateNext == SHIFT) || (stateNext == HOLD);
        busyNext   = (stateNext != IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            bitCntReg  <= '0;
            shiftReg   <= '0;
            rxShiftReg <= '0;
            rxDataReg  <= '0;
            isReadReg  <= 1'b0;
            enableReg  <= 1'b0;
            busyReg    <= 1'b0;
            txDoneReg  <= 1'b0;
            rxDoneReg  <= 1'b0;
`ifdef LCD_REG_SPI_VERIFY_EN
            addrReg      <= '0;
            dataReg      <= '0;
            autoReadReg  <= 1'b0;
            verifyErrReg <= 1'b0;
`endif
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            bitCntReg  <= bitCntNext;
            shiftReg   <= shiftNext;
            rxShiftReg <= rxShiftNext;
            rxDataReg  <= rxDataNext;
            isReadReg  <= isReadNext;
            enableReg  <= enableNext;
            busyReg    <= busyNext;
            txDoneReg  <= txDoneNext;
            rxDoneReg  <= rxDoneNext;
`ifdef LCD_REG_SPI_VERIFY_EN
            addrReg      <= addrNext;
            dataReg      <= dataNext;
            autoReadReg  <= autoReadNext;
            verifyErrReg <= verifyErrNext;
`endif
        end
    end

    assign o_clock        = sclk;
    assign o_txSerial     = shiftReg[FRAME_BITS-1];
    assign o_serialEnable = enableReg;
    assign o_busy         = busyReg;
    assign o_txDone       = txDoneReg;
    assign o_rxDone       = rxDoneReg;
    assign o_rxData       = rxDataReg;
`ifdef LCD_REG_SPI_VERIFY_EN
    assign o_verifyErr    = verifyErrReg;
`endif

endmodule

// File: tb/tb_lcd_reg_spi.sv
// -----------------------------------------------------------------------------
// tb_lcd_reg_spi
// Bench for lcd_reg_spi. A driver issues strobes and pushes the expected frame
// and completion event into queues; a panel model decodes frames from the pins
// and answers reads from its own register file; a monitor checks every done
// pulse against the expected queue. Honours LCD_REG_SPI_VERIFY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_reg_spi;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int IDLE_GAP = 4;
    // Strobe-to-done latency of one frame.
    localparam int LAT = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;
`ifdef LCD_REG_SPI_VERIFY_EN
    // A write is followed by a readback that starts after a full idle gap.
    localparam int WLAT = 2 * LAT + IDLE_GAP - 1;
`else
    localparam int WLAT = LAT;
`endif

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_txBegin = 1'b0;
    logic       i_rxBegin = 1'b0;
    logic [6:0] i_address = '0;
    logic [7:0] i_txData = '0;
    logic       i_rxSerial = 1'b0;
    logic       o_clock, o_txSerial, o_serialEnable, o_busy, o_txDone, o_rxDone;
    logic [7:0] o_rxData;
`ifdef LCD_REG_SPI_VERIFY_EN
    logic       o_verifyErr;
`endif

    lcd_reg_spi #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_txBegin      (i_txBegin),
        .i_rxBegin      (i_rxBegin),
        .i_address      (i_address),
        .i_txData       (i_txData),
        .i_rxSerial     (i_rxSerial),
        .o_clock        (o_clock),
        .o_txSerial     (o_txSerial),
        .o_serialEnable (o_serialEnable),
        .o_busy         (o_busy),
        .o_txDone       (o_txDone),
        .o_rxDone       (o_rxDone),
`ifdef LCD_REG_SPI_VERIFY_EN
        .o_verifyErr    (o_verifyErr),
`endif
        .o_rxData       (o_rxData)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        bit         isRead;
        logic [6:0] addr;
        logic [7:0] data;
        int         doneCyc;
        bit         expErr;
    } done_t;

    typedef struct {
        bit         isRead;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

    done_t      doneQ[$];
    frame_t     frameQ[$];
    logic [7:0] refMem[128];
    logic [7:0] panelMem[128];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         freeAt = 0;
    int         doneCount = 0;
    int         edgeCnt = 0;
    int         lastLowRun = -1;
    bit         corruptRd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name, input string msg);
        tests++;
        fails++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : cycCounter
        forever begin
            @(posedge i_clock);
            cyc++;
        end
    end

    // Panel model: decodes frames on SCLK rises, answers reads after falls.
    initial begin : panel
        logic       pSclk, pEn, pRw;
        int         pBits, lowRun;
        bit         seenFall;
        logic [15:0] pFrame;
        logic [7:0]  rdByte;
        frame_t      f;
        pSclk = 1'b0; pEn = 1'b0; pRw = 1'b0; pBits = 0; lowRun = 0;
        seenFall = 1'b0; pFrame = '0; rdByte = '0;
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                pBits    = 0;
                lowRun   = 0;
                seenFall = 1'b0;
            end else begin
                if (o_clock && !pSclk) begin
                    edgeCnt++;
                    pFrame = {pFrame[14:0], o_txSerial};
                    pBits++;
                    if (pBits == 16 && pFrame[15] == 1'b0) panelMem[pFrame[14:8]] = pFrame[7:0];
                end
                if (!o_clock && pSclk) begin
                    edgeCnt++;
                    if (pBits == 8) begin
                        pRw    = pFrame[7];
                        rdByte = panelMem[pFrame[6:0]] ^ {7'd0, corruptRd};
                    end
                    if (pBits >= 8 && pBits < 16) begin
                        i_rxSerial = pRw ? rdByte[15 - pBits] : 1'($urandom_range(0, 1));
                    end
                end
                if (pEn && !o_serialEnable) begin
                    if (pBits == 16) begin
                        if (frameQ.size() == 0) begin
                            failNow("unexpected_frame", $sformatf("frame 0x%04h", pFrame));
                        end else begin
                            f = frameQ.pop_front();
                            check("frame_bits", pFrame, {f.isRead, f.addr, f.data});
                        end
                    end else if (pBits != 0) begin
                        failNow("partial_frame", $sformatf("%0d bits", pBits));
                    end
                    pBits    = 0;
                    lowRun   = 0;
                    seenFall = 1'b1;
                end
                if (!o_serialEnable) lowRun++;
                if (!pEn && o_serialEnable && seenFall) lastLowRun = lowRun;
            end
            pSclk = o_clock;
            pEn   = o_serialEnable;
        end
    end

    // Monitor: every done pulse is matched against the expected queue.
    initial begin : monitor
        logic [7:0] lastRx;
        done_t      e;
        lastRx = 8'h00;
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                lastRx = 8'h00;
            end else if (o_txDone || o_rxDone) begin
                doneCount++;
                if (doneQ.size() == 0) begin
                    check("unexpected_done", {30'd0, o_txDone, o_rxDone}, 32'd0);
                end else begin
                    e = doneQ.pop_front();
                    check("done_kind", {30'd0, o_txDone, o_rxDone}, e.isRead ? 32'd1 : 32'd2);
                    check("done_cycle", cyc, e.doneCyc);
                    check("busy_at_done", o_busy, 1'b1);
                    if (e.isRead) begin
                        check("rx_data", o_rxData, e.data);
                        lastRx = e.data;
                    end else begin
                        check("rx_data_hold", o_rxData, lastRx);
`ifdef LCD_REG_SPI_VERIFY_EN
                        check("verify_err", o_verifyErr, e.expErr);
`endif
                    end
                    $display("[TB] cyc=%0d %s addr=0x%02h data=0x%02h", cyc,
                             e.isRead ? "read " : "write", e.addr, e.isRead ? o_rxData : e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic waitFree();
        while (cyc < freeAt) tick(1);
    endtask

    // Drives one strobe cycle; the model decides whether it is accepted.
    task automatic drive(input bit tx, input bit rx, input logic [6:0] a, input logic [7:0] d);
        done_t  e;
        frame_t f;
        i_txBegin = tx;
        i_rxBegin = rx;
        i_address = a;
        i_txData  = d;
        if ((tx || rx) && cyc >= freeAt) begin
            e.isRead  = !tx;
            e.addr    = a;
            e.data    = tx ? d : refMem[a];
            e.doneCyc = cyc + (tx ? WLAT : LAT);
            e.expErr  = corruptRd;
            freeAt    = e.doneCyc + IDLE_GAP - 1;
            f.isRead  = !tx;
            f.addr    = a;
            f.data    = tx ? d : 8'h00;
            frameQ.push_back(f);
`ifdef LCD_REG_SPI_VERIFY_EN
            if (tx) begin
                f.isRead = 1'b1;
                f.data   = 8'h00;
                frameQ.push_back(f);
            end
`endif
            if (tx) refMem[a] = d;
            doneQ.push_back(e);
        end
        tick(1);
        i_txBegin = 1'b0;
        i_rxBegin = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((doneQ.size() != 0 || frameQ.size() != 0) && t < 3000) begin
            tick(1);
            t++;
        end
        check("drain_timeout", doneQ.size() + frameQ.size(), 0);
        tick(2);
    endtask

    initial begin : stimulus
        int         base, t, oldV;
        logic [7:0] v;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            refMem[i]   = v;
            panelMem[i] = v;
        end
        refMem[5]   = 8'h5C;
        panelMem[5] = 8'h5C;

        tick(3);
        check("reset_clock", o_clock, 1'b0);
        check("reset_mosi", o_txSerial, 1'b0);
        check("reset_enable", o_serialEnable, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_txdone", o_txDone, 1'b0);
        check("reset_rxdone", o_rxDone, 1'b0);
        check("reset_rxdata", o_rxData, 8'h00);
`ifdef LCD_REG_SPI_VERIFY_EN
        check("reset_verify", o_verifyErr, 1'b0);
`endif
        i_reset = 1'b0;
        freeAt  = cyc;

        // Write 0x12 <- 0xA5, then read 0x05 (panel holds 0x5C).
        drive(1'b1, 1'b0, 7'h12, 8'hA5);
        drain();
        waitFree();
        drive(1'b0, 1'b1, 7'h05, 8'h00);
        drain();

        // Simultaneous strobes (write wins), then strobes while busy.
        waitFree();
        base = doneCount;
        drive(1'b1, 1'b1, 7'h21, 8'h77);
        tick(20);
        drive(1'b0, 1'b1, 7'h22, 8'h00);
        tick(40);
        drive(1'b1, 1'b0, 7'h23, 8'h11);
        drain();
        waitFree();
        tick(10);
        check("single_done_count", doneCount - base, 1);

        // Back-to-back writes: second strobe on the first IDLE cycle.
        waitFree();
        drive(1'b1, 1'b0, 7'h30, 8'h01);
        waitFree();
        drive(1'b1, 1'b0, 7'h31, 8'h02);
        tick(5);
        check("gap_low_cycles", lastLowRun, IDLE_GAP);
        drain();

        // Reset on the 7th SCLK edge aborts the frame silently.
        waitFree();
        oldV = int'(refMem[7'h40]);
        base = edgeCnt;
        drive(1'b1, 1'b0, 7'h40, 8'hEE);
        t = 0;
        while (edgeCnt - base < 7 && t < 500) begin
            tick(1);
            t++;
        end
        check("abort_edge_wait", (t < 500) ? 1 : 0, 1);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("abort_enable", o_serialEnable, 1'b0);
        check("abort_clock", o_clock, 1'b0);
        check("abort_busy", o_busy, 1'b0);
        doneQ.delete();
        frameQ.delete();
        refMem[7'h40] = 8'(oldV);
        freeAt = cyc;
        base = doneCount;
        tick(200);
        check("abort_no_done", doneCount - base, 0);
        drive(1'b1, 1'b0, 7'h41, 8'h5A);
        drain();

`ifdef LCD_REG_SPI_VERIFY_EN
        // Readback returns 0x3D for a written 0x3C.
        waitFree();
        corruptRd = 1'b1;
        drive(1'b1, 1'b0, 7'h50, 8'h3C);
        drain();
        corruptRd = 1'b0;
        check("verify_sticky", o_verifyErr, 1'b1);
        waitFree();
        drive(1'b1, 1'b0, 7'h51, 8'h3C);
        tick(2);
        check("verify_cleared", o_verifyErr, 1'b0);
        drain();
`endif

        // Randomised traffic with occasional strobes dropped while busy.
        for (int n = 0; n < 40; n++) begin
            int         k;
            logic [6:0] a;
            logic [7:0] d;
            waitFree();
            tick($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            a = 7'($urandom_range(0, 15));
            d = 8'($urandom);
            drive(k < 4 || k >= 8, k >= 4, a, d);
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 100));
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      7'($urandom_range(0, 15)), 8'($urandom));
            end
        end
        drain();
        waitFree();
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
